// File: rtl/sc_game_pkg.sv
// ---------------------------------------------------------------------------
// sc_game_pkg
// Shared definitions for the game slice: the 2-bit level codes that travel
// from the game state machine to the referee, and the referee state
// encodings. Kept as plain localparam constants so older consumers of the
// encodings can use them without enum casting.
// No ports (package).
// ---------------------------------------------------------------------------
package sc_game_pkg;

    typedef logic [1:0] level_t;
    typedef logic [1:0] ref_state_t;

    // Level codes: 0 means no game in progress, 1..3 are playable levels.
    localparam level_t LVL_NONE = 2'd0;
    localparam level_t LVL_1    = 2'd1;
    localparam level_t LVL_2    = 2'd2;
    localparam level_t LVL_3    = 2'd3;

    // Referee states.
    localparam ref_state_t REF_IDLE = 2'd0;
    localparam ref_state_t REF_RUN  = 2'd1;
    localparam ref_state_t REF_DONE = 2'd2;

endpackage

// File: rtl/sc_tick_divider.sv
// ---------------------------------------------------------------------------
// sc_tick_divider
// Free-running clock divider with a period chosen per cycle by the caller.
// The count runs 0 .. period_i-1 while enabled, then wraps to 0; term_o is
// high combinationally on the enabled cycle where the count sits at its
// last value, so the caller can register its own tick from it.
// Ports:
//   clk_i     in   1      system clock
//   rstn_i    in   1      synchronous active-low reset
//   clear_i   in   1      synchronous restart to count 0 (wins over en_i)
//   en_i      in   1      advance the count this cycle
//   period_i  in   DIV_W  clocks per terminal pulse (>= 2)
//   term_o    out  1      terminal-count indication for this cycle
// ---------------------------------------------------------------------------
module sc_tick_divider #(
    parameter int DIV_W = 26
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             term_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] lastCount;

    assign lastCount = period_i - 1'b1;

    // The terminal flag is suppressed while clearing so a restart never
    // produces a stray tick in the same cycle.
    assign term_o = en_i && !clear_i && (cnt_q == lastCount);

    // Next count: clear has priority, otherwise count up and wrap at the end
    // of the period; hold when not enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == lastCount) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_level_referee.sv
// ---------------------------------------------------------------------------
// sc_level_referee
// Per-level referee sitting in front of the game state machine. It paces the
// game with a level-dependent step tick, counts the steps survived in the
// current level, and reports the outcome as one-cycle active-low win/lose
// pulses. Once a pulse is issued the referee parks in DONE until the level
// code changes, so each level attempt yields exactly one outcome pulse.
// Ports:
//   SC_LEVELREFEREE_CLOCK_50     in   1        system clock
//   SC_LEVELREFEREE_RESET_InLow  in   1        synchronous active-low reset
//   SC_LEVELREFEREE_nivel        in   2        current level (0 = no game)
//   SC_LEVELREFEREE_clear_InLow  in   1        synchronous clear, same effect as reset
//   SC_LEVELREFEREE_crash_InLow  in   1        collision flag, low = crash
//   SC_LEVELREFEREE_win_outLow   out  1        one-cycle low pulse: target reached
//   SC_LEVELREFEREE_lose_outLow  out  1        one-cycle low pulse: crashed
//   SC_LEVELREFEREE_tick_out     out  1        one-cycle high pulse per step
//   SC_LEVELREFEREE_score        out  SCORE_W  steps survived in this level
// ---------------------------------------------------------------------------
module sc_level_referee
    import sc_game_pkg::*;
#(
    parameter int DIV_W     = 26,
    parameter int DIV_L1    = 25_000_000,
    parameter int DIV_L2    = 16_000_000,
    parameter int DIV_L3    = 10_000_000,
    parameter int SCORE_W   = 5,
    parameter int TARGET_L1 = 10,
    parameter int TARGET_L2 = 15,
    parameter int TARGET_L3 = 20
) (
    input  logic               SC_LEVELREFEREE_CLOCK_50,
    input  logic               SC_LEVELREFEREE_RESET_InLow,
    input  logic [1:0]         SC_LEVELREFEREE_nivel,
    input  logic               SC_LEVELREFEREE_clear_InLow,
    input  logic               SC_LEVELREFEREE_crash_InLow,
    output logic               SC_LEVELREFEREE_win_outLow,
    output logic               SC_LEVELREFEREE_lose_outLow,
    output logic               SC_LEVELREFEREE_tick_out,
    output logic [SCORE_W-1:0] SC_LEVELREFEREE_score
);

    ref_state_t         state_q, state_d;
    level_t             nivel_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic               tick_q, tick_d;

    level_t             nivel;
    logic               syncRstn;
    logic               levelChange;
    logic               crashNow;
    logic               runActive;
    logic               divTerm;
    logic [DIV_W-1:0]   divPeriod;
    logic [SCORE_W-1:0] target;
    logic [SCORE_W-1:0] scorePlus;

    assign nivel       = SC_LEVELREFEREE_nivel;
    assign syncRstn    = SC_LEVELREFEREE_RESET_InLow && SC_LEVELREFEREE_clear_InLow;
    assign levelChange = (nivel != nivel_q);
    assign crashNow    = !SC_LEVELREFEREE_crash_InLow;
    assign scorePlus   = score_q + 1'b1;

    // The divider only runs during a settled RUN cycle; a level change or a
    // drop to no-game restarts it so the new level starts a full period.
    assign runActive = (state_q == REF_RUN) && (nivel != LVL_NONE) && !levelChange;

    // Period and win target follow the live level code, so a level change
    // takes effect in the same cycle the referee restarts.
    always_comb begin
        divPeriod = DIV_W'(DIV_L1);
        target    = SCORE_W'(TARGET_L1);
        case (nivel)
            LVL_2: begin
                divPeriod = DIV_W'(DIV_L2);
                target    = SCORE_W'(TARGET_L2);
            end
            LVL_3: begin
                divPeriod = DIV_W'(DIV_L3);
                target    = SCORE_W'(TARGET_L3);
            end
            default: begin
                divPeriod = DIV_W'(DIV_L1);
                target    = SCORE_W'(TARGET_L1);
            end
        endcase
    end

    // A crash freezes the divider so no tick can coincide with a lose.
    sc_tick_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clk_i    (SC_LEVELREFEREE_CLOCK_50),
        .rstn_i   (syncRstn),
        .clear_i  (!runActive),
        .en_i     (!crashNow),
        .period_i (divPeriod),
        .term_o   (divTerm)
    );

    // Referee FSM. No-game overrides everything. Inside RUN the order is
    // level change, then crash, then tick, which gives a crash priority over
    // a final tick landing in the same cycle. Pulse outputs default to
    // their inactive level so every pulse lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        win_d   = 1'b1;
        lose_d  = 1'b1;
        tick_d  = 1'b0;
        if (nivel == LVL_NONE) begin
            state_d = REF_IDLE;
            score_d = '0;
        end else begin
            case (state_q)
                REF_IDLE: begin
                    state_d = REF_RUN;
                    score_d = '0;
                end
                REF_RUN: begin
                    if (levelChange) begin
                        score_d = '0;
                    end else if (crashNow) begin
                        lose_d  = 1'b0;
                        state_d = REF_DONE;
                    end else if (divTerm) begin
                        tick_d  = 1'b1;
                        score_d = scorePlus;
                        if (scorePlus == target) begin
                            win_d   = 1'b0;
                            state_d = REF_DONE;
                        end
                    end
                end
                REF_DONE: begin
                    if (levelChange) begin
                        state_d = REF_RUN;
                        score_d = '0;
                    end
                end
                default: begin
                    state_d = REF_IDLE;
                    score_d = '0;
                end
            endcase
        end
    end

    // State and output registers; reset and clear share the same effect.
    always_ff @(posedge SC_LEVELREFEREE_CLOCK_50) begin
        if (!syncRstn) begin
            state_q <= REF_IDLE;
            nivel_q <= LVL_NONE;
            score_q <= '0;
            win_q   <= 1'b1;
            lose_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nivel_q <= nivel;
            score_q <= score_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            tick_q  <= tick_d;
        end
    end

    assign SC_LEVELREFEREE_win_outLow  = win_q;
    assign SC_LEVELREFEREE_lose_outLow = lose_q;
    assign SC_LEVELREFEREE_tick_out    = tick_q;
    assign SC_LEVELREFEREE_score       = score_q;

endmodule

// File: tb/tb_sc_level_referee.sv
// ---------------------------------------------------------------------------
// tb_sc_level_referee
// Directed bench for sc_level_referee with small dividers/targets so whole
// levels play out in a few dozen cycles. Inputs change on the falling edge
// and outputs are checked on the following falling edge.
// ---------------------------------------------------------------------------
module tb_sc_level_referee;

    localparam int DIV_L1 = 4;
    localparam int DIV_L2 = 3;
    localparam int DIV_L3 = 2;
    localparam int TGT_L1 = 3;
    localparam int TGT_L2 = 4;
    localparam int TGT_L3 = 5;

    logic       clk;
    logic       rstN;
    logic       clrN;
    logic [1:0] nivel;
    logic       crashN;
    logic       winN;
    logic       loseN;
    logic       tick;
    logic [4:0] score;

    int vectorCount = 0;
    int missCount   = 0;

    sc_level_referee #(
        .DIV_W     (26),
        .DIV_L1    (DIV_L1),
        .DIV_L2    (DIV_L2),
        .DIV_L3    (DIV_L3),
        .SCORE_W   (5),
        .TARGET_L1 (TGT_L1),
        .TARGET_L2 (TGT_L2),
        .TARGET_L3 (TGT_L3)
    ) dut (
        .SC_LEVELREFEREE_CLOCK_50    (clk),
        .SC_LEVELREFEREE_RESET_InLow (rstN),
        .SC_LEVELREFEREE_nivel       (nivel),
        .SC_LEVELREFEREE_clear_InLow (clrN),
        .SC_LEVELREFEREE_crash_InLow (crashN),
        .SC_LEVELREFEREE_win_outLow  (winN),
        .SC_LEVELREFEREE_lose_outLow (loseN),
        .SC_LEVELREFEREE_tick_out    (tick),
        .SC_LEVELREFEREE_score       (score)
    );

    // 10-time-unit clock, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of inputs and let exactly one rising edge consume them.
    task automatic applyStimulus(input logic r, input logic c, input logic [1:0] n, input logic cr);
        rstN   = r;
        clrN   = c;
        nivel  = n;
        crashN = cr;
        @(negedge clk);
    endtask

    // Compare all four outputs against the expected values.
    task automatic checkOutput(input string tag, input logic expTick, input logic [4:0] expScore,
                               input logic expWin, input logic expLose);
        vectorCount++;
        assert (tick === expTick) else begin
            missCount++;
            $error("[TB] FAIL %s tick: observed %0b expected %0b", tag, tick, expTick);
        end
        vectorCount++;
        assert (score === expScore) else begin
            missCount++;
            $error("[TB] FAIL %s score: observed %0d expected %0d", tag, score, expScore);
        end
        vectorCount++;
        assert (winN === expWin) else begin
            missCount++;
            $error("[TB] FAIL %s win: observed %0b expected %0b", tag, winN, expWin);
        end
        vectorCount++;
        assert (loseN === expLose) else begin
            missCount++;
            $error("[TB] FAIL %s lose: observed %0b expected %0b", tag, loseN, expLose);
        end
    endtask

    // Play a level with no crash for the given number of edges. Edge 0 is the
    // entry into RUN; ticks land every div edges after that, the win pulse
    // coincides with tick number target, and nothing moves afterwards.
    task automatic runLevel(input string tag, input logic [1:0] lvl, input int div,
                            input int target, input int steps);
        int     ticks;
        logic   expTick;
        for (int k = 0; k <= steps; k++) begin
            applyStimulus(1'b1, 1'b1, lvl, 1'b1);
            ticks   = (k / div > target) ? target : k / div;
            expTick = (k > 0) && (k % div == 0) && (k / div <= target);
            checkOutput($sformatf("%s k%0d", tag, k), expTick, 5'(ticks),
                        (k == div * target) ? 1'b0 : 1'b1, 1'b1);
        end
    endtask

    initial begin
        $display("[TB] sc_level_referee directed test start");

        // Reset held with a level already requested: outputs stay idle.
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        checkOutput("reset c0", 1'b0, 5'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        checkOutput("reset c1", 1'b0, 5'd0, 1'b1, 1'b1);

        // Level 1 to a win, then idle in DONE.
        runLevel("lvl1 win", 2'd1, DIV_L1, TGT_L1, 15);

        // Level 2 after the win: fresh score, faster tick, single win pulse.
        runLevel("lvl2 win", 2'd2, DIV_L2, TGT_L2, 14);

        // Level 3, crash one cycle after score reaches 2.
        runLevel("lvl3 pre", 2'd3, DIV_L3, TGT_L3, 4);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
        checkOutput("lvl3 crash", 1'b0, 5'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b1);
        checkOutput("lvl3 after", 1'b0, 5'd2, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd3, 1'b1);
            checkOutput($sformatf("lvl3 done k%0d", k), 1'b0, 5'd2, 1'b1, 1'b1);
        end

        // Level 1 again, crash exactly on the edge of the final tick.
        runLevel("lvl1 pre", 2'd1, DIV_L1, TGT_L1, 11);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0);
        checkOutput("lvl1 crash+tick", 1'b0, 5'd2, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd1, 1'b1);
            checkOutput($sformatf("lvl1 done k%0d", k), 1'b0, 5'd2, 1'b1, 1'b1);
        end

        // Mid-run abort through clear.
        runLevel("lvl2 clr", 2'd2, DIV_L2, TGT_L2, 6);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b1);
        checkOutput("clear abort", 1'b0, 5'd0, 1'b1, 1'b1);

        // Mid-run abort through reset.
        runLevel("lvl2 rst", 2'd2, DIV_L2, TGT_L2, 6);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b1);
        checkOutput("reset abort", 1'b0, 5'd0, 1'b1, 1'b1);

        // Mid-run abort through level 0, then stay idle.
        runLevel("lvl2 nv0", 2'd2, DIV_L2, TGT_L2, 6);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b1);
        checkOutput("nivel0 abort", 1'b0, 5'd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 1'b1);
            checkOutput($sformatf("idle k%0d", k), 1'b0, 5'd0, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
